// File: rtl/pkg_sfGeneration.sv
// Shared types for the SF generation pipeline: sequencer states, stage bit indices
// and small helpers mapping phase states onto stage numbers.
package pkg_sfGeneration;

    localparam int unsigned STAGE_W  = 4;
    localparam int unsigned PHASE_W  = 2;

    localparam int unsigned DXYP5    = 0;
    localparam int unsigned FXYP5    = 1;
    localparam int unsigned FXYNORM  = 2;
    localparam int unsigned FS       = 3;

    typedef enum logic [2:0] {
        S_Reset,
        S_Ready,
        S_DXYP5,
        S_FXYP5,
        S_FXYNORM,
        S_FS,
        S_Done
    } STATES_t;

    function automatic logic is_phase(input STATES_t s);
        return (s == S_DXYP5) || (s == S_FXYP5) || (s == S_FXYNORM) || (s == S_FS);
    endfunction

    function automatic logic [PHASE_W-1:0] phase_of(input STATES_t s);
        case (s)
            S_FXYP5:   return PHASE_W'(FXYP5);
            S_FXYNORM: return PHASE_W'(FXYNORM);
            S_FS:      return PHASE_W'(FS);
            default:   return PHASE_W'(DXYP5);
        endcase
    endfunction

    function automatic logic [STAGE_W-1:0] stage_onehot(input logic [PHASE_W-1:0] p);
        return STAGE_W'(1) << p;
    endfunction

endpackage

// File: rtl/sf_phase_watchdog.sv
// Per-phase cycle counter; expired rises once LIMIT cycles have been counted since clear.
module sf_phase_watchdog #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            expired <= 1'b0;
        end else if (clear) begin
            count   <= '0;
            expired <= 1'b0;
        end else if (enable && !expired) begin
            count   <= count + CNT_W'(1);
            expired <= (count == CNT_W'(LIMIT - 1));
        end
    end

endmodule

// File: rtl/sf_stage_sequencer.sv
// Sequences the four SF stages per window for num_windows windows, with abort and
// an optional per-phase watchdog (enabled by defining SFSEQ_WATCHDOG_EN).
module sf_stage_sequencer
    import pkg_sfGeneration::*;
#(
    parameter int unsigned WIN_W       = 8,
    parameter int unsigned WDOG_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIN_W-1:0]     num_windows,
    input  logic                 abort,
    input  logic [STAGE_W-1:0]   stage_done,
    output logic [STAGE_W-1:0]   stage_start,
    output logic [WIN_W-1:0]     window_idx,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic                 err,
    output logic [PHASE_W-1:0]   err_phase
);

    if (WDOG_CYCLES < 2) begin : g_bad_wdog
        $error("WDOG_CYCLES must be at least 2");
    end

    STATES_t              state_q, state_d;
    logic [WIN_W-1:0]     count_q, count_d;
    logic [WIN_W-1:0]     idx_d;
    logic                 aborted_d, err_d, busy_d, done_d;
    logic [PHASE_W-1:0]   err_phase_d, cur_phase;
    logic [STAGE_W-1:0]   stage_start_d;
    logic                 stage_ok;

`ifdef SFSEQ_WATCHDOG_EN
    logic wdog_expired, wdog_clear, wdog_enable;

    assign wdog_clear  = |stage_start_d;
    assign wdog_enable = is_phase(state_q);

    sf_phase_watchdog #(.LIMIT(WDOG_CYCLES)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wdog_clear),
        .enable  (wdog_enable),
        .expired (wdog_expired)
    );
`endif

    assign cur_phase = phase_of(state_q);
    // A done bit seen during its own start cycle is stale and must not advance the FSM.
    assign stage_ok  = stage_done[cur_phase] && !stage_start[cur_phase];

    // Next state and next registered outputs.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        idx_d       = window_idx;
        aborted_d   = aborted;
`ifdef SFSEQ_WATCHDOG_EN
        err_d       = err;
        err_phase_d = err_phase;
`else
        err_d       = 1'b0;
        err_phase_d = '0;
`endif
        case (state_q)
            S_Reset: state_d = S_Ready;
            S_Ready: begin
                if (start) begin
                    idx_d       = '0;
                    aborted_d   = 1'b0;
                    err_d       = 1'b0;
                    err_phase_d = '0;
                    if (num_windows != '0) begin
                        count_d = num_windows;
                        state_d = S_DXYP5;
                    end else begin
                        state_d = S_Done;
                    end
                end
            end
            S_DXYP5, S_FXYP5, S_FXYNORM, S_FS: begin
                if (abort) begin
                    state_d   = S_Done;
                    aborted_d = 1'b1;
                end else if (stage_ok) begin
                    case (state_q)
                        S_DXYP5:   state_d = S_FXYP5;
                        S_FXYP5:   state_d = S_FXYNORM;
                        S_FXYNORM: state_d = S_FS;
                        default: begin
                            if (window_idx == count_q - WIN_W'(1)) begin
                                state_d = S_Done;
                            end else begin
                                idx_d   = window_idx + WIN_W'(1);
                                state_d = S_DXYP5;
                            end
                        end
                    endcase
`ifdef SFSEQ_WATCHDOG_EN
                end else if (wdog_expired) begin
                    state_d     = S_Done;
                    err_d       = 1'b1;
                    err_phase_d = cur_phase;
`endif
                end
            end
            S_Done:  state_d = S_Ready;
            default: state_d = S_Reset;
        endcase

        stage_start_d = '0;
        if (is_phase(state_d) && (state_d != state_q)) begin
            stage_start_d = stage_onehot(phase_of(state_d));
        end
        busy_d = (state_d != S_Reset) && (state_d != S_Ready);
        done_d = (state_d == S_Done);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_Reset;
            count_q     <= '0;
            window_idx  <= '0;
            aborted     <= 1'b0;
            err         <= 1'b0;
            err_phase   <= '0;
            stage_start <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            window_idx  <= idx_d;
            aborted     <= aborted_d;
            err         <= err_d;
            err_phase   <= err_phase_d;
            stage_start <= stage_start_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

endmodule

// File: tb/tb_sf_stage_sequencer.sv
// Directed self-checking bench for sf_stage_sequencer; the watchdog scenario runs
// only when SFSEQ_WATCHDOG_EN is defined.
module tb_sf_stage_sequencer;

    localparam int unsigned WIN_W = 8;
    localparam int unsigned WDOG  = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [WIN_W-1:0] num_windows = '0;
    logic             abort = 1'b0;
    logic [3:0]       stage_done = '0;
    logic [3:0]       stage_start;
    logic [WIN_W-1:0] window_idx;
    logic             busy, done, aborted, err;
    logic [1:0]       err_phase;

    int checks = 0;
    int failures = 0;
    int n_pulses, n_done, pend, cd, cyc;
    logic found;

    sf_stage_sequencer #(.WIN_W(WIN_W), .WDOG_CYCLES(WDOG)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_windows (num_windows),
        .abort       (abort),
        .stage_done  (stage_done),
        .stage_start (stage_start),
        .window_idx  (window_idx),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .err         (err),
        .err_phase   (err_phase)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Precondition: first cycle of stage k. Returns in the first cycle of the next state.
    task automatic finish_stage(input int k);
        stage_done = '0;
        tick();
        stage_done[k] = 1'b1;
        tick();
        stage_done = '0;
    endtask

    initial begin
        // Reset: asynchronous, all outputs low
        #2 rst = 1'b1;
        #2;
        check("rst_stage_start", 32'(stage_start), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_outs", {window_idx, done, aborted, err, err_phase}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        check("ready_busy", 32'(busy), 0);

        // Two windows, each stage_done three cycles after its start
        start = 1'b1; num_windows = 8'd2;
        tick();
        start = 1'b0;
        n_pulses = 0; n_done = 0; pend = -1; cd = 0;
        for (int c = 0; c < 120 && n_done == 0; c++) begin
            stage_done = '0;
            if (stage_start != 4'b0) begin
                check("seq_order", 32'(stage_start), 32'(4'b0001 << (n_pulses % 4)));
                check("seq_idx", 32'(window_idx), 32'(n_pulses / 4));
                pend = n_pulses % 4;
                cd = 3;
                n_pulses++;
            end else if (pend >= 0) begin
                cd--;
                if (cd == 0) begin
                    stage_done[pend] = 1'b1;
                    pend = -1;
                end
            end
            if (done) n_done++;
            tick();
        end
        stage_done = '0;
        check("seq_pulses", 32'(n_pulses), 8);
        check("seq_done_count", 32'(n_done), 1);
        check("seq_busy_after", 32'(busy), 0);
        check("seq_done_after", 32'(done), 0);
        check("seq_idx_hold", 32'(window_idx), 1);

        // Zero windows: done one cycle after start, no stage starts
        start = 1'b1; num_windows = 8'd0;
        tick();
        start = 1'b0;
        check("zero_done", 32'(done), 1);
        check("zero_start0", 32'(stage_start), 0);
        tick();
        check("zero_done_end", 32'(done), 0);
        check("zero_busy", 32'(busy), 0);
        check("zero_start1", 32'(stage_start), 0);

        // Abort beats stage_done[1] in FXYP5
        start = 1'b1; num_windows = 8'd1;
        tick();
        start = 1'b0;
        check("ab_s0", 32'(stage_start), 32'(4'b0001));
        finish_stage(0);
        check("ab_s1", 32'(stage_start), 32'(4'b0010));
        tick();
        abort = 1'b1; stage_done = 4'b0010;
        tick();
        abort = 1'b0; stage_done = '0;
        check("ab_done", 32'(done), 1);
        check("ab_aborted", 32'(aborted), 1);
        check("ab_no_s2", 32'(stage_start), 0);
        check("ab_err", 32'(err), 0);
        tick();
        check("ab_ready_busy", 32'(busy), 0);
        check("ab_hold_aborted", 32'(aborted), 1);
        check("ab_no_s2_late", 32'(stage_start), 0);

        // Wrong-stage done and start while busy are ignored
        start = 1'b1; num_windows = 8'd1;
        tick();
        start = 1'b0;
        check("ign_s0", 32'(stage_start), 32'(4'b0001));
        check("ign_clear_aborted", 32'(aborted), 0);
        tick();
        stage_done = 4'b1000;
        tick();
        tick();
        stage_done = '0; start = 1'b1; num_windows = 8'd5;
        tick();
        start = 1'b0;
        check("ign_no_start", 32'(stage_start), 0);
        check("ign_busy", 32'(busy), 1);
        check("ign_no_done", 32'(done), 0);
        stage_done = 4'b0001;
        tick();
        stage_done = '0;
        check("ign_still_dxyp5", 32'(stage_start), 32'(4'b0010));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ign_abort_done", 32'(done), 1);
        check("ign_idx", 32'(window_idx), 0);
        tick();

`ifdef SFSEQ_WATCHDOG_EN
        // Watchdog fires in FXYNORM when stage_done[2] never arrives
        start = 1'b1; num_windows = 8'd1;
        tick();
        start = 1'b0;
        finish_stage(0);
        finish_stage(1);
        check("wd_s2", 32'(stage_start), 32'(4'b0100));
        found = 1'b0;
        cyc = 1;
        for (int c = 1; c <= 40 && !found; c++) begin
            if (done) begin
                found = 1'b1;
                cyc = c;
            end else begin
                tick();
            end
        end
        check("wd_done_seen", 32'(found), 1);
        check("wd_not_early", 32'(cyc > int'(WDOG)), 1);
        check("wd_err", 32'(err), 1);
        check("wd_err_phase", 32'(err_phase), 2);
        check("wd_not_aborted", 32'(aborted), 0);
        tick();
        check("wd_hold_err", 32'(err), 1);
        check("wd_busy", 32'(busy), 0);
`else
        check("nowd_err", 32'(err), 0);
        check("nowd_err_phase", 32'(err_phase), 0);
`endif

        // Reset mid-FXYNORM: outputs drop immediately, no done for that job
        start = 1'b1; num_windows = 8'd3;
        tick();
        start = 1'b0;
        finish_stage(0);
        finish_stage(1);
        check("mr_s2", 32'(stage_start), 32'(4'b0100));
        tick();
        check("mr_busy_pre", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check("mr_busy", 32'(busy), 0);
        check("mr_outs", {stage_start, window_idx, done, aborted, err, err_phase}, 0);
        tick();
        rst = 1'b0;
        tick();
        check("mr_ready_done", 32'(done), 0);
        check("mr_ready_busy", 32'(busy), 0);
        start = 1'b1; num_windows = 8'd1;
        tick();
        start = 1'b0;
        check("mr_restart", 32'(stage_start), 32'(4'b0001));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("mr_abort_done", 32'(done), 1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sf_stage_sequencer.md
SF_STAGE_SEQUENCER -- requirements
Module: sf_stage_sequencer

Interface
REQ-001 SHALL have parameter WIN_W, default 8: width of the window count and window index.
REQ-002 SHALL have parameter WDOG_CYCLES, default 1024: per-phase watchdog limit in cycles (used only when SFSEQ_WATCHDOG_EN is defined).
REQ-003 SHALL have ports, one per line:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  request to process num_windows windows.
- num_windows  in  WIN_W  window count; sampled only when start is accepted.
- abort  in  1  terminate the job early.
- stage_done  in  4  per-stage completion; bit0=DXYP5, bit1=FXYP5, bit2=FXYNORM, bit3=FS.
- stage_start  out  4  one-cycle start pulse per stage, same bit order.
- window_idx  out  WIN_W  index of the window in process.
- busy  out  1  job in progress.
- done  out  1  one-cycle job-complete pulse.
- aborted  out  1  last job ended by abort.
- err  out  1  last job ended by watchdog.
- err_phase  out  2  stage that timed out, encoded 0..3.

Function
REQ-004 SHALL use FSM states S_Reset, S_Ready, S_DXYP5, S_FXYP5, S_FXYNORM, S_FS and S_Done.
REQ-005 SHALL go from S_Reset to S_Ready on the first clock after rst deasserts.
REQ-006 SHALL, in S_Ready when start=1 and num_windows!=0, latch num_windows, clear window_idx/aborted/err/err_phase, and go to S_DXYP5.
REQ-007 SHALL, in S_Ready when start=1 and num_windows=0, go to S_Done and issue no stage_start.
REQ-008 SHALL assert stage_start[k], registered, for exactly the first cycle spent in the phase state for stage k; no other bits are high in that cycle.
REQ-009 SHALL ignore stage_done[k] in the cycle stage_start[k] is high, and ignore it in any state not belonging to stage k.
REQ-010 SHALL advance DXYP5->FXYP5->FXYNORM->FS on the matching stage_done bit (one cycle after done seen).
REQ-011 SHALL, on stage_done[3] in S_FS: go to S_Done if window_idx==latched count-1; otherwise increment window_idx and go to S_DXYP5.
REQ-012 SHALL, on abort=1 in any phase state, go to S_Done and set aborted=1; abort takes priority over a simultaneous stage_done; abort in S_Ready/S_Done is ignored.
REQ-013 SHALL drive busy=1 in S_DXYP5..S_Done and busy=0 in S_Reset and S_Ready.
REQ-014 SHALL pulse done for the single cycle in S_Done, then go to S_Ready; window_idx, aborted, err and err_phase hold until the next accepted start.
REQ-015 SHALL ignore start while busy=1; no queuing.
REQ-016 SHALL give window_idx no wrap-around: its maximum is 2^WIN_W-2, since count-1 ≤ 2^WIN_W-2.

Reset
REQ-017 SHALL, on rst=1 at any time (including mid-job), enter S_Reset and drive all outputs to 0 asynchronously.
REQ-018 SHALL drop any in-flight stage handshake on reset; no done pulse is issued for the interrupted job.

Configuration
REQ-019 SHALL, with SFSEQ_WATCHDOG_EN defined, clear a cycle counter on each phase-state entry and increment it each cycle in that state.
REQ-020 SHALL, when that counter reaches WDOG_CYCLES without the matching stage_done, go to S_Done with err=1 and err_phase=stage; stage_done in the same cycle wins; abort beats the watchdog.
REQ-021 SHALL, without SFSEQ_WATCHDOG_EN, contain no counter logic and tie err and err_phase to 0.

Structure
REQ-022 SHALL take STATES_t from shared package pkg_sfGeneration, which also holds the stage bit-index constants (DXYP5=0, FXYP5=1, FXYNORM=2, FS=3).
REQ-023 SHALL put the watchdog counter in sub-module sf_phase_watchdog (inputs clear/enable, output expired), instantiated only under SFSEQ_WATCHDOG_EN.

Verification
REQ-024 SHALL cover: num_windows=2, each stage_done 3 cycles after its start -> 8 stage_start pulses in order 0,1,2,3,0,1,2,3; window_idx 0 then 1; one done pulse; busy low after it.
REQ-025 SHALL cover: start with num_windows=0 -> done pulses 1 cycle after start; stage_start stays 0.
REQ-026 SHALL cover: abort and stage_done[1] in the same cycle in S_FXYP5 -> S_Done, aborted=1, no stage_start[2].
REQ-027 SHALL cover: watchdog on, WDOG_CYCLES=16, stage_done[2] never returned -> err=1, err_phase=2, done pulse.
REQ-028 SHALL cover: stage_done[3] raised during S_DXYP5 -> ignored, FSM stays in S_DXYP5; start while busy -> ignored.
REQ-029 SHALL cover: rst asserted mid-S_FXYNORM -> all outputs 0 immediately; after release, S_Ready within 1 cycle.
